// File: rtl/seg_scan_ctrl_if.sv
// Handshake and display-pin bundle between the lab FSM, the scan controller and the board pins.
interface seg_scan_ctrl_if;
   logic [31:0] num_in;
   logic        num_valid;
   logic        num_ready;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output num_in, num_valid,
      input  num_ready, busy, an, seg, dp
   );

   modport slave (
      input  num_in, num_valid,
      output num_ready, busy, an, seg, dp
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment sequencer: accepts a value, converts it to BCD by double-dabble,
// commits the digits atomically and time-multiplexes them onto the shared an/seg pins.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 100000
) (
   input logic           clk,
   input logic           reset,
   seg_scan_ctrl_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic             w_ready;
   logic             w_busy;
   logic             w_accept;
   logic             w_isInit;
   logic             w_isBlank;
   logic             w_isSpecial;

   logic [29:0]      r_work;
   logic [29:0]      w_adj;
   logic [3:0]       r_bitCnt;
   logic [15:0]      r_digits;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_index;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic [3:0]       w_curDigit;
   logic [6:0]       w_segNext;

   assign w_isInit    = (bus.num_in == 32'hFFFF_FFFF);
   assign w_isBlank   = (bus.num_in == 32'hFFFF_FFFE);
   assign w_isSpecial = (bus.num_in > 32'd9999);
   assign w_accept    = bus.num_valid && w_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_isSpecial) w_nextState = CONVERT;
         CONVERT: if (r_bitCnt == 4'd13)        w_nextState = COMMIT;
         COMMIT:                                w_nextState = IDLE;
         default:                               w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_ready = (r_state == IDLE) && !reset;
      w_busy  = (r_state != IDLE);
   end

   // Upper 16 bits of r_work hold the BCD accumulator, lower 14 bits the binary being shifted in.
   always_comb begin
      w_adj = r_work;
      for (int k = 0; k < 4; k++) begin
         if (r_work[14 + 4*k +: 4] >= 4'd5)
            w_adj[14 + 4*k +: 4] = r_work[14 + 4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_digits <= 16'hBBBB;
         r_work   <= '0;
         r_bitCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_isInit)         r_digits <= 16'hBBA1;
                  else if (w_isBlank)   r_digits <= 16'hBBBB;
                  else if (w_isSpecial) r_digits <= 16'hCCCC;
                  else begin
                     r_work   <= {16'h0000, bus.num_in[13:0]};
                     r_bitCnt <= '0;
                  end
               end
            end
            CONVERT: begin
               r_work   <= w_adj << 1;
               r_bitCnt <= r_bitCnt + 4'd1;
            end
            COMMIT:  r_digits <= r_work[29:14];
            default: ;
         endcase
      end
   end

   assign w_curDigit = r_digits[4*r_index +: 4];

   always_comb begin
      case (w_curDigit)
         4'h0:    w_segNext = 7'b1000000;
         4'h1:    w_segNext = 7'b1111001;
         4'h2:    w_segNext = 7'b0100100;
         4'h3:    w_segNext = 7'b0110000;
         4'h4:    w_segNext = 7'b0011001;
         4'h5:    w_segNext = 7'b0010010;
         4'h6:    w_segNext = 7'b0000010;
         4'h7:    w_segNext = 7'b1111000;
         4'h8:    w_segNext = 7'b0000000;
         4'h9:    w_segNext = 7'b0010000;
         4'hA:    w_segNext = 7'b0001001;
         4'hC:    w_segNext = 7'b0111111;
         default: w_segNext = 7'b1111111;
      endcase
   end

   // Scan keeps running through conversions and commits; the pins lag the index by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_index <= '0;
         r_an    <= 4'b1110;
         r_seg   <= 7'h7F;
      end else begin
         if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_cnt   <= '0;
            r_index <= r_index + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_an  <= ~(4'b0001 << r_index);
         r_seg <= w_segNext;
      end
   end

   assign bus.num_ready = w_ready;
   assign bus.busy      = w_busy;
   assign bus.an        = r_an;
   assign bus.seg       = r_seg;
   assign bus.dp        = 1'b1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed and randomized values checked against an arithmetic digit model.
module tb_seg_scan_ctrl;

   localparam int REFRESH_DIV = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] curDigits;

   always #5 clk = ~clk;

   seg_scan_ctrl_if ifc ();

   seg_scan_ctrl #(.REFRESH_DIV(REFRESH_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] segOf(input logic [3:0] code);
      logic [6:0] table16 [16];
      for (int i = 0; i < 16; i++) table16[i] = 7'h7F;
      table16[0]  = 7'b1000000; table16[1] = 7'b1111001; table16[2] = 7'b0100100;
      table16[3]  = 7'b0110000; table16[4] = 7'b0011001; table16[5] = 7'b0010010;
      table16[6]  = 7'b0000010; table16[7] = 7'b1111000; table16[8] = 7'b0000000;
      table16[9]  = 7'b0010000; table16[10] = 7'b0001001; table16[12] = 7'b0111111;
      return table16[code];
   endfunction

   function automatic logic [15:0] modelDigits(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) return 16'hBBA1;
      if (v == 32'hFFFF_FFFE) return 16'hBBBB;
      if (v > 32'd9999)       return 16'hCCCC;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic sampleDisplay(input string tag, input logic [15:0] digits, output int idx);
      idx = -1;
      for (int i = 0; i < 4; i++)
         if (ifc.an == ~(4'b0001 << i)) idx = i;
      checkOutput({tag, "_anOneHot"}, 32'($countones(~ifc.an)), 32'd1);
      if (idx >= 0)
         checkOutput({tag, "_seg"}, {25'd0, ifc.seg}, {25'd0, segOf(digits[4*idx +: 4])});
   endtask

   task automatic checkDisplay(input string tag, input logic [15:0] digits);
      logic [3:0] seen;
      int idx;
      seen = '0;
      tick;
      repeat (4 * REFRESH_DIV) begin
         sampleDisplay(tag, digits, idx);
         if (idx >= 0) seen[idx] = 1'b1;
         tick;
      end
      checkOutput({tag, "_allScanned"}, {28'd0, seen}, 32'hF);
      checkOutput({tag, "_dp"}, {31'd0, ifc.dp}, 32'd1);
   endtask

   task automatic acceptValue(input logic [31:0] v);
      int waitCnt;
      waitCnt = 0;
      ifc.num_in    = v;
      ifc.num_valid = 1'b1;
      while (!ifc.num_ready && waitCnt < 100) begin
         tick;
         waitCnt++;
      end
      checkOutput("readyBeforeAccept", {31'd0, ifc.num_ready}, 32'd1);
      tick;
   endtask

   task automatic applyStimulus(input logic [31:0] v);
      int idx;
      acceptValue(v);
      ifc.num_valid = 1'b0;
      if (v <= 32'd9999) begin
         for (int c = 1; c <= 15; c++) begin
            checkOutput("busyDuringConvert", {31'd0, ifc.busy}, 32'd1);
            checkOutput("readyDuringConvert", {31'd0, ifc.num_ready}, 32'd0);
            sampleDisplay("holdOldDigits", curDigits, idx);
            tick;
         end
      end
      checkOutput("busyAfterAccept", {31'd0, ifc.busy}, 32'd0);
      checkOutput("readyAfterAccept", {31'd0, ifc.num_ready}, 32'd1);
      curDigits = modelDigits(v);
   endtask

   initial begin
      int idx;
      logic [31:0] v;

      reset         = 1'b1;
      ifc.num_in    = '0;
      ifc.num_valid = 1'b0;
      curDigits     = 16'hBBBB;

      repeat (3) tick;
      checkOutput("resetReady", {31'd0, ifc.num_ready}, 32'd0);
      checkOutput("resetBusy", {31'd0, ifc.busy}, 32'd0);
      checkOutput("resetAn", {28'd0, ifc.an}, 32'hE);
      checkOutput("resetSeg", {25'd0, ifc.seg}, 32'h7F);
      checkOutput("resetDp", {31'd0, ifc.dp}, 32'd1);

      reset = 1'b0;
      #1;
      checkOutput("readyAfterRelease", {31'd0, ifc.num_ready}, 32'd1);
      for (int k = 0; k < 2 * REFRESH_DIV; k++) begin
         tick;
         checkOutput("scanDwellAn", {28'd0, ifc.an}, (k < REFRESH_DIV) ? 32'hE : 32'hD);
         checkOutput("scanDwellSeg", {25'd0, ifc.seg}, 32'h7F);
      end

      applyStimulus(32'd1234);
      checkDisplay("d1234", 16'h1234);
      applyStimulus(32'd42);
      checkDisplay("d0042", 16'h0042);

      applyStimulus(32'hFFFF_FFFF);
      checkDisplay("initH1", 16'hBBA1);
      applyStimulus(32'hFFFF_FFFE);
      checkDisplay("allBlank", 16'hBBBB);

      applyStimulus(32'd10000);
      checkDisplay("over10000", 16'hCCCC);
      applyStimulus(32'h8000_0000);
      checkDisplay("overMsb", 16'hCCCC);
      applyStimulus(32'd9999);
      checkDisplay("d9999", 16'h9999);

      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: v = 32'($urandom_range(0, 9999));
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'hFFFF_FFFE;
            default: begin
               v = $urandom;
               if (v <= 32'd9999) v = v + 32'd10000;
            end
         endcase
         repeat ($urandom_range(0, 3)) tick;
         applyStimulus(v);
         checkDisplay("random", modelDigits(v));
      end

      // Second value held on the bus throughout the first conversion.
      acceptValue(32'd5678);
      ifc.num_in = 32'd1;
      for (int c = 1; c <= 15; c++) begin
         checkOutput("heldReadyLow", {31'd0, ifc.num_ready}, 32'd0);
         checkOutput("heldBusy", {31'd0, ifc.busy}, 32'd1);
         tick;
      end
      checkOutput("heldReadyIdle", {31'd0, ifc.num_ready}, 32'd1);
      tick;
      ifc.num_valid = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         checkOutput("secondBusy", {31'd0, ifc.busy}, 32'd1);
         sampleDisplay("show5678", 16'h5678, idx);
         tick;
      end
      checkOutput("secondDone", {31'd0, ifc.busy}, 32'd0);
      curDigits = 16'h0001;
      checkDisplay("d0001", 16'h0001);

      applyStimulus(32'd42);
      checkDisplay("preAbort", 16'h0042);
      acceptValue(32'd1234);
      ifc.num_valid = 1'b0;
      repeat (6) tick;
      checkOutput("busyBeforeAbort", {31'd0, ifc.busy}, 32'd1);
      reset = 1'b1;
      repeat (2) tick;
      checkOutput("readyInAbortReset", {31'd0, ifc.num_ready}, 32'd0);
      reset = 1'b0;
      tick;
      checkOutput("busyAfterAbort", {31'd0, ifc.busy}, 32'd0);
      checkOutput("readyAfterAbort", {31'd0, ifc.num_ready}, 32'd1);
      curDigits = 16'hBBBB;
      checkDisplay("abortBlank", 16'hBBBB);
      repeat (20) tick;
      checkDisplay("abortNoCommit", 16'hBBBB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
